multicycle_sequencer: RTL and testbench



---
 rtl/seq_pkg.sv | 53 +++++
 rtl/mem_wait_timer.sv | 25 ++
 rtl/multicycle_sequencer.sv | 171 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared opcode, ALU-code and state definitions for the multicycle sequencer.
package seq_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd3;
  localparam logic [5:0] OP_LW   = 6'd4;
  localparam logic [5:0] OP_SW   = 6'd5;
  localparam logic [5:0] OP_AND  = 6'd6;
  localparam logic [5:0] OP_OR   = 6'd7;
  localparam logic [5:0] OP_NOR  = 6'd8;
  localparam logic [5:0] OP_BEQ  = 6'd9;
  localparam logic [5:0] OP_BNE  = 6'd10;
  localparam logic [5:0] OP_SLT  = 6'd11;
  localparam logic [5:0] OP_EOF  = 6'd12;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } seq_state_e;

  function automatic logic [3:0] alu_op(input logic [5:0] op);
    logic [3:0] code;
    code = ALU_ADD;
    unique case (op)
      OP_SUB, OP_BEQ, OP_BNE: code = ALU_SUB;
      OP_AND:                 code = ALU_AND;
      OP_OR:                  code = ALU_OR;
      OP_NOR:                 code = ALU_NOR;
      OP_SLT:                 code = ALU_SLT;
      default:                code = ALU_ADD;
    endcase
    return code;
  endfunction

  function automatic logic uses_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM-state cycles without an acknowledge; flags the last allowed cycle.
module mem_wait_timer #(
  parameter int unsigned Timeout = 15
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_q <= 8'd0;
    end else if (en_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  // Count starts at 0 on MEM entry, so the Timeout-th cycle sees Timeout-1.
  assign expired_o = (count_q == 8'(Timeout - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM with data-memory timeout halt.
// Optional retired-instruction counter enabled by SEQ_RETIRE_CNT_EN.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef SEQ_RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_sel,
  output logic [3:0]  alu_control,
  output logic        alu_src_b,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_write,
  output logic        wb_data_sel,
  output logic        wb_addr_sel,
  output logic        halted,
  output logic        error,
`ifdef SEQ_RETIRE_CNT_EN
  output logic [CNT_W-1:0] retired_cnt,
`endif
  output logic [2:0]  state
);

  seq_state_e state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       error_q, error_d;
  logic       expired;

  logic unused_instr;
  assign unused_instr = ^instr[25:0];

  mem_wait_timer #(
    .Timeout (MEM_TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (state_q != StMem),
    .en_i      ((state_q == StMem) && !mem_ack),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch: begin
        opcode_d = instr[31:26];
        state_d  = StDecode;
      end
      StDecode: begin
        if (opcode_q == OP_EOF) begin
          state_d = StHalt;
        end else if (opcode_q >= OP_ADD && opcode_q <= OP_SLT) begin
          state_d = StExec;
        end else begin
          state_d = StFetch;
        end
      end
      StExec: begin
        if (opcode_q == OP_LW || opcode_q == OP_SW) begin
          state_d = StMem;
        end else if (opcode_q == OP_BEQ || opcode_q == OP_BNE) begin
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d = (opcode_q == OP_SW) ? StFetch : StWb;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = StHalt;
        end
      end
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      opcode_q <= OP_NOP;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 1'b0;
    alu_control = ALU_ADD;
    alu_src_b   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_write   = 1'b0;
    wb_data_sel = 1'b0;
    wb_addr_sel = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      StFetch:  ir_write = 1'b1;
      StDecode: begin
        if (opcode_q == OP_NOP || opcode_q > OP_EOF) pc_write = 1'b1;
      end
      StExec: begin
        alu_control = alu_op(opcode_q);
        alu_src_b   = uses_imm(opcode_q);
        if (opcode_q == OP_BEQ) begin
          pc_write = 1'b1;
          pc_sel   = alu_zero;
        end else if (opcode_q == OP_BNE) begin
          pc_write = 1'b1;
          pc_sel   = ~alu_zero;
        end
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_we    = (opcode_q == OP_SW);
        alu_src_b = 1'b1;
        pc_write  = mem_ack && (opcode_q == OP_SW);
      end
      StWb: begin
        reg_write   = 1'b1;
        pc_write    = 1'b1;
        wb_data_sel = (opcode_q == OP_LW);
        wb_addr_sel = (opcode_q == OP_LW) || (opcode_q == OP_ADDI);
      end
      StHalt:   halted = 1'b1;
      default:  ;
    endcase
  end

  assign error = error_q;
  assign state = state_q;

`ifdef SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (pc_write || (state_q == StDecode && opcode_q == OP_EOF)) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: cycle trace table plus timeout/reset sequences.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, alu_zero, mem_ack;
  logic [31:0] instr;
  logic        ir_write, pc_write, pc_sel, alu_src_b, mem_req, mem_we;
  logic        reg_write, wb_data_sel, wb_addr_sel, halted, error;
  logic [3:0]  alu_control;
  logic [2:0]  state;
`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .MEM_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .mem_ack     (mem_ack),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .alu_control (alu_control),
    .alu_src_b   (alu_src_b),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .reg_write   (reg_write),
    .wb_data_sel (wb_data_sel),
    .wb_addr_sel (wb_addr_sel),
    .halted      (halted),
    .error       (error),
`ifdef SEQ_RETIRE_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .state       (state)
  );

  logic [14:0] outs;
  assign outs = {ir_write, pc_write, pc_sel, alu_control, alu_src_b, mem_req, mem_we,
                 reg_write, wb_data_sel, wb_addr_sel, halted, error};

  typedef struct {
    logic        start;
    logic [5:0]  op;
    logic        zero;
    logic        ack;
    logic [2:0]  st;
    logic [14:0] o;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] eo(input logic ir, pw, ps, input logic [3:0] alu,
                                     input logic sb, mr, mw, rw, wd, wa, h, e);
    return {ir, pw, ps, alu, sb, mr, mw, rw, wd, wa, h, e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic s, input logic [5:0] op, input logic z, input logic a,
                      input logic [2:0] st, input logic [14:0] o);
    vec_t v;
    v.start = s; v.op = op; v.zero = z; v.ack = a; v.st = st; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic t_alu(input logic [5:0] op, input logic [3:0] alu, input logic imm);
    push(0, op, 0, 0, 3'd1, eo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1, 6'h3f, 0, 1, 3'd2, '0);
    push(0, 6'h3f, 1, 0, 3'd3, eo(0, 0, 0, alu, imm, 0, 0, 0, 0, 0, 0, 0));
    push(0, 6'h3f, 0, 0, 3'd5, eo(0, 1, 0, 0, 0, 0, 0, 1, 0, imm, 0, 0));
  endtask

  task automatic t_nop(input logic [5:0] op);
    push(0, op, 0, 0, 3'd1, eo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 6'h3f, 0, 1, 3'd2, eo(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic t_br(input logic [5:0] op, input logic z, input logic ps);
    push(0, op, 0, 0, 3'd1, eo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 6'h3f, 0, 0, 3'd2, '0);
    push(0, 6'h3f, z, 0, 3'd3, eo(0, 1, ps, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic t_mem(input logic [5:0] op, input int w);
    logic st_op;
    st_op = (op == 6'd5);
    push(0, op, 0, 0, 3'd1, eo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 6'h3f, 0, 0, 3'd2, '0);
    push(0, 6'h3f, 0, 1, 3'd3, eo(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < w; k++) push(0, 6'h3f, 0, 0, 3'd4, eo(0, 0, 0, 0, 1, 1, st_op, 0, 0, 0, 0, 0));
    push(0, 6'h3f, 0, 1, 3'd4, eo(0, st_op, 0, 0, 1, 1, st_op, 0, 0, 0, 0, 0));
    if (!st_op) push(0, 6'h3f, 0, 1, 3'd5, eo(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // From IDLE, fetch op and advance to the first MEM cycle.
  task automatic to_mem(input logic [5:0] op);
    start = 1'b1; tick(); start = 1'b0;
    instr = {op, 26'h155_5555}; tick();
    instr = 32'hffff_ffff; tick(); tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_zero = 1'b0; mem_ack = 1'b0; instr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", 32'(outs), 32'd0);

    push(0, 6'h3f, 0, 1, 3'd0, '0);
    push(1, 6'h3f, 0, 0, 3'd0, '0);
    t_alu(6'd1, 4'd0, 0);
    t_alu(6'd6, 4'd2, 0);
    t_alu(6'd3, 4'd0, 1);
    t_alu(6'd2, 4'd1, 0);
    t_alu(6'd7, 4'd3, 0);
    t_alu(6'd8, 4'd4, 0);
    t_alu(6'd11, 4'd5, 0);
    t_nop(6'd0);
    t_nop(6'd13);
    t_nop(6'd63);
    t_br(6'd9, 1, 1);
    t_br(6'd10, 1, 0);
    t_br(6'd9, 0, 0);
    t_br(6'd10, 0, 1);
    t_mem(6'd4, 3);
    t_mem(6'd5, 1);
    push(0, 6'd12, 0, 0, 3'd1, eo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 6'h3f, 0, 0, 3'd2, '0);
    push(1, 6'h3f, 0, 0, 3'd6, eo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    push(1, 6'h3f, 1, 1, 3'd6, eo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      instr = {vecs[i].op, 26'h2aa_aaaa};
      alu_zero = vecs[i].zero;
      mem_ack = vecs[i].ack;
      #1;
      chk($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("row%0d_outs", i), 32'(outs), 32'(vecs[i].o));
      tick();
    end
`ifdef SEQ_RETIRE_CNT_EN
    chk("retired_after_trace", retired_cnt, 32'd17);
`endif

    // sw that never gets an ack: timeout halt after 15 MEM cycles.
    do_reset();
    chk("after_reset_state", 32'(state), 32'd0);
    to_mem(6'd5);
    for (int k = 1; k <= 15; k++) begin
      mem_ack = 1'b0;
      #1;
      chk($sformatf("to_mem%0d_state", k), 32'(state), 32'd4);
      chk($sformatf("to_mem%0d_req_pw_err", k), {29'd0, mem_req, pc_write, error}, 32'b100);
      tick();
    end
    start = 1'b1;
    #1;
    chk("to_halt_state", 32'(state), 32'd6);
    chk("to_halt_outs", 32'(outs), 32'(eo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)));
    tick();
    start = 1'b0;
    #1;
    chk("to_halt_sticky", 32'({state, halted, error}), 32'({3'd6, 1'b1, 1'b1}));
    do_reset();
    #1;
    chk("reset_clears_err", 32'({state, outs}), 32'd0);

    // Ack in the timeout cycle wins.
    to_mem(6'd5);
    for (int k = 1; k <= 15; k++) begin
      mem_ack = (k == 15);
      #1;
      chk($sformatf("ack15_mem%0d_state", k), 32'(state), 32'd4);
      chk($sformatf("ack15_mem%0d_pw", k), 32'(pc_write), 32'(k == 15));
      tick();
    end
    mem_ack = 1'b0;
    #1;
    chk("ack15_next_state", 32'(state), 32'd1);
    chk("ack15_no_error", 32'({halted, error}), 32'd0);

    // Reset in the second MEM cycle of sw.
    do_reset();
    to_mem(6'd5);
    #1;
    chk("rst_mem1_state", 32'(state), 32'd4);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mem2_req", 32'(mem_req), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mem_state", 32'(state), 32'd0);
    chk("rst_mem_outs", 32'(outs), 32'd0);
`ifdef SEQ_RETIRE_CNT_EN
    chk("rst_mem_retired", retired_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
